// File: rtl/uart_rx_mv.sv
// uart_rx_mv: 8-bit UART receiver with a 2-FF input synchronizer and
// 3-point majority-vote sampling of every bit.
// Frame: idle high, start bit, 8 data bits LSB first, optional parity, 1 stop bit.
// Ports:
//   i_Clock       system clock
//   i_Reset       synchronous reset, active-high
//   i_Rx_Serial   asynchronous serial input, idle high
//   o_Rx_Byte     last good received byte (held until the next good frame)
//   o_Rx_DV       one-cycle pulse, o_Rx_Byte updated
//   o_Frame_Err   one-cycle pulse, stop bit sampled low
//   o_Parity_Err  one-cycle pulse, parity mismatch
//   o_Busy        high whenever the receiver is not idle
module uart_rx_mv #(
    parameter int CLKS_PER_BIT = 868,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_Rx_Serial,
    output logic [7:0] o_Rx_Byte,
    output logic       o_Rx_DV,
    output logic       o_Frame_Err,
    output logic       o_Parity_Err,
    output logic       o_Busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int H  = CLKS_PER_BIT / 2;
    localparam int Q  = CLKS_PER_BIT / 8;

    localparam logic [CW-1:0] C_SAMP0 = CW'(H - Q);
    localparam logic [CW-1:0] C_SAMP1 = CW'(H);
    localparam logic [CW-1:0] C_SAMP2 = CW'(H + Q);
    localparam logic [CW-1:0] C_LAST  = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    state_t          r_State;
    logic            r_Rx_Meta;
    logic            r_Rx_Sync;
    logic [CW-1:0]   r_Clk_Cnt;
    logic [2:0]      r_Bit_Idx;
    logic [7:0]      r_Shift;
    logic [1:0]      r_Samp;
    logic            r_Par_Err;

    logic            w_Rx_S;
    logic            w_Maj;
    logic            w_Decide;
    logic            w_Last;
    logic            w_Par_Exp;

    // Both stages reset high so a reset never looks like a start edge.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_Rx_Meta <= 1'b1;
            r_Rx_Sync <= 1'b1;
        end else begin
            r_Rx_Meta <= i_Rx_Serial;
            r_Rx_Sync <= r_Rx_Meta;
        end
    end

    assign w_Rx_S    = r_Rx_Sync;
    // Third sample is taken live at the decision point.
    assign w_Maj     = (r_Samp[0] & r_Samp[1]) | (r_Samp[0] & w_Rx_S) | (r_Samp[1] & w_Rx_S);
    assign w_Decide  = (r_Clk_Cnt == C_SAMP2);
    assign w_Last    = (r_Clk_Cnt == C_LAST);
    assign w_Par_Exp = (^r_Shift) ^ (PARITY_ODD != 0);
    assign o_Busy    = (r_State != S_IDLE);

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_State      <= S_IDLE;
            r_Clk_Cnt    <= '0;
            r_Bit_Idx    <= '0;
            r_Shift      <= '0;
            r_Samp       <= '0;
            r_Par_Err    <= 1'b0;
            o_Rx_Byte    <= '0;
            o_Rx_DV      <= 1'b0;
            o_Frame_Err  <= 1'b0;
            o_Parity_Err <= 1'b0;
        end else begin
            o_Rx_DV      <= 1'b0;
            o_Frame_Err  <= 1'b0;
            o_Parity_Err <= 1'b0;
            r_Clk_Cnt    <= r_Clk_Cnt + CW'(1);
            if (r_Clk_Cnt == C_SAMP0) r_Samp[0] <= w_Rx_S;
            if (r_Clk_Cnt == C_SAMP1) r_Samp[1] <= w_Rx_S;

            unique case (r_State)
                S_IDLE: begin
                    r_Clk_Cnt <= '0;
                    if (!w_Rx_S) begin
                        r_State   <= S_START;
                        r_Bit_Idx <= '0;
                        r_Par_Err <= 1'b0;
                    end
                end
                S_START: begin
                    // Majority high at the decision point is a glitch; otherwise
                    // ride out the rest of the start bit so data bits are timed
                    // from their own bit boundaries.
                    if (w_Decide && w_Maj) begin
                        r_State   <= S_IDLE;
                        r_Clk_Cnt <= '0;
                    end else if (w_Last) begin
                        r_State   <= S_DATA;
                        r_Clk_Cnt <= '0;
                    end
                end
                S_DATA: begin
                    if (w_Decide) r_Shift <= {w_Maj, r_Shift[7:1]};
                    if (w_Last) begin
                        r_Clk_Cnt <= '0;
                        r_Bit_Idx <= r_Bit_Idx + 3'd1;
                        if (r_Bit_Idx == 3'd7)
                            r_State <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
                    end
                end
                S_PARITY: begin
                    if (w_Decide) r_Par_Err <= w_Maj ^ w_Par_Exp;
                    if (w_Last) begin
                        r_State   <= S_STOP;
                        r_Clk_Cnt <= '0;
                    end
                end
                S_STOP: begin
                    // Leave at the decision point for early resync.
                    if (w_Decide) begin
                        r_Clk_Cnt <= '0;
                        if (w_Maj) begin
                            r_State <= S_IDLE;
                            if (r_Par_Err) begin
                                o_Parity_Err <= 1'b1;
                            end else begin
                                o_Rx_Byte <= r_Shift;
                                o_Rx_DV   <= 1'b1;
                            end
                        end else begin
                            r_State     <= S_BREAK;
                            o_Frame_Err <= 1'b1;
                        end
                    end
                end
                S_BREAK: begin
                    r_Clk_Cnt <= '0;
                    if (w_Rx_S) r_State <= S_IDLE;
                end
                default: begin
                    r_State   <= S_IDLE;
                    r_Clk_Cnt <= '0;
                end
            endcase
        end
    end
endmodule
